// File: rtl/bus_mem_slave.sv
// Unibus slave RAM window answering DATI/DATIP/DATO/DATOB via MSYN/SSYN handshake,
// with an ARM-side register set to load and inspect the RAM through an auto-incrementing pointer.
module bus_mem_slave #(
  parameter logic [17:0] BASE   = 18'o000000,
  parameter int          NWL2   = 12,
  parameter int          DESKEW = 15
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        msyn_in_h,
  input  logic        init_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam int DW     = $clog2(DESKEW + 2);
  localparam int NWORDS = 1 << NWL2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DESKEW  = 3'd1,
    S_NOMATCH = 3'd2,
    S_ACCESS  = 3'd3,
    S_REPLY   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_RD   = 2'd1,
    PEND_WR   = 2'd2
  } pend_t;

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_dcnt;
  logic            r_enable;
  logic [NWL2-1:0] r_armptr;
  pend_t           r_armpend;
  logic [15:0]     r_armdata;
  logic            r_armrd_d;
  logic [31:0]     r_count;
  logic            r_ssyn;
  logic [15:0]     r_dout;
  logic [15:0]     r_rdata;
  logic [15:0]     r_mem [NWORDS];

  logic            w_match;
  logic            w_bus_acc;
  logic            w_arm_op;
  logic            w_reg_wr2;
  logic            w_reg_wr3;
  logic            w_reply_hold;
  logic            w_reply_done;
  logic [NWL2-1:0] w_addr;
  logic [15:0]     w_wdata;
  logic            w_we_hi;
  logic            w_we_lo;
  logic            w_unused;

  assign w_match      = r_enable && (a_in_h[17:NWL2+1] == BASE[17:NWL2+1]);
  assign w_bus_acc    = (r_state == S_ACCESS);
  assign w_arm_op     = (r_armpend != PEND_NONE) && !w_bus_acc;
  assign w_reg_wr2    = armwrite && (armwaddr == 3'd2) && (r_armpend == PEND_NONE);
  assign w_reg_wr3    = armwrite && (armwaddr == 3'd3) && (r_armpend == PEND_NONE);
  assign w_reply_hold = (r_state == S_REPLY) && msyn_in_h && !init_in_h;
  assign w_reply_done = (r_state == S_REPLY) && !msyn_in_h && !init_in_h;
  assign w_unused     = &{1'b0, armwdata};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (msyn_in_h) w_next = S_DESKEW;
      S_DESKEW: begin
        if (!msyn_in_h)                     w_next = S_IDLE;
        else if (r_dcnt == DESKEW[DW-1:0])  w_next = w_match ? S_ACCESS : S_NOMATCH;
      end
      S_NOMATCH: if (!msyn_in_h) w_next = S_IDLE;
      S_ACCESS:  w_next = S_REPLY;
      S_REPLY:   if (!msyn_in_h) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (init_in_h) w_next = S_IDLE;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_dcnt  <= (r_state == S_DESKEW) ? r_dcnt + DW'(1) : '0;
    end
  end

  // Single RAM port: the bus owns it during ACCESS, any pending ARM op takes every other cycle.
  always_comb begin
    w_addr  = r_armptr;
    w_wdata = r_armdata;
    w_we_hi = 1'b0;
    w_we_lo = 1'b0;
    if (w_bus_acc) begin
      w_addr  = a_in_h[NWL2:1];
      w_wdata = d_in_h;
      case (c_in_h)
        2'b10: begin
          w_we_hi = 1'b1;
          w_we_lo = 1'b1;
        end
        2'b11: begin
          w_we_hi = a_in_h[0];
          w_we_lo = !a_in_h[0];
        end
        default: ;
      endcase
    end else if (r_armpend == PEND_WR) begin
      w_we_hi = 1'b1;
      w_we_lo = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (w_we_hi) r_mem[w_addr][15:8] <= w_wdata[15:8];
    if (w_we_lo) r_mem[w_addr][7:0]  <= w_wdata[7:0];
    r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_enable  <= 1'b0;
      r_armptr  <= '0;
      r_armpend <= PEND_NONE;
      r_armdata <= '0;
      r_armrd_d <= 1'b0;
      r_count   <= '0;
    end else begin
      r_armrd_d <= w_arm_op && (r_armpend == PEND_RD);
      if (armwrite && (armwaddr == 3'd1)) r_enable <= armwdata[31];
      if (w_reg_wr2) begin
        r_armptr  <= armwdata[NWL2-1:0];
        r_armpend <= PEND_RD;
      end else if (w_reg_wr3) begin
        r_armdata <= armwdata[15:0];
        r_armpend <= PEND_WR;
      end else if (w_arm_op) begin
        r_armptr  <= r_armptr + NWL2'(1);
        r_armpend <= PEND_NONE;
      end
      if (r_armrd_d && !w_reg_wr3) r_armdata <= r_rdata;
      if (armwrite && (armwaddr == 3'd4)) r_count <= '0;
      else if (w_reply_done)              r_count <= r_count + 32'd1;
    end
  end

  // Read data is latched on the first REPLY cycle, while r_rdata still holds the bus word.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_ssyn <= 1'b0;
      r_dout <= '0;
    end else if (w_reply_hold) begin
      r_ssyn <= 1'b1;
      if (!r_ssyn) r_dout <= c_in_h[1] ? 16'h0000 : r_rdata;
    end else begin
      r_ssyn <= 1'b0;
      r_dout <= '0;
    end
  end

  assign ssyn_out_h = r_ssyn;
  assign d_out_h    = r_dout;

  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      3'd0: armrdata = 32'h424D3005;
      3'd1: armrdata = {r_enable, 1'b0, (r_armpend != PEND_NONE), r_state, 8'h00, BASE};
      3'd2: armrdata = {14'h0, {(18-NWL2){1'b0}}, r_armptr};
      3'd3: armrdata = {16'h0, r_armdata};
      3'd4: armrdata = r_count;
      default: armrdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Testbench for bus_mem_slave: fixed vector table, hand-written INIT/abort/collision sequences,
// and random bus cycles checked against an array-based model of the RAM window.
module tb_bus_mem_slave;

  localparam logic [17:0] BASE    = 18'o000000;
  localparam int          NWL2    = 12;
  localparam int          DESKEW  = 15;
  localparam int          ACK_LAT = DESKEW + 3;
  localparam int          NWORDS  = 1 << NWL2;
  localparam logic [1:0]  DATI = 2'b00, DATIP = 2'b01, DATO = 2'b10, DATOB = 2'b11;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        armwrite = 1'b0;
  logic [2:0]  armraddr = 3'd0;
  logic [2:0]  armwaddr = 3'd0;
  logic [31:0] armwdata = 32'h0;
  logic [31:0] armrdata;
  logic [17:0] a_in_h = '0;
  logic [1:0]  c_in_h = '0;
  logic [15:0] d_in_h = '0;
  logic        msyn_in_h = 1'b0;
  logic        init_in_h = 1'b0;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  int errors = 0;
  int checks = 0;

  logic [15:0] tbMem [NWORDS];
  bit          known [NWORDS];
  int          mCount = 0;
  int          mPtr = 0;
  logic        mEn = 1'b0;

  typedef struct {
    logic        en;
    logic [17:0] a;
    logic [1:0]  c;
    logic [15:0] d;
    logic        expAck;
    logic [15:0] expD;
  } vec_t;

  vec_t vecs[14];

  bus_mem_slave #(.BASE(BASE), .NWL2(NWL2), .DESKEW(DESKEW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
    .msyn_in_h(msyn_in_h), .init_in_h(init_in_h),
    .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour of one bus cycle: window decode, byte lanes, cycle counter.
  function automatic logic modelBus(input logic en, input logic [17:0] a, input logic [1:0] c,
                                    input logic [15:0] d, output logic [15:0] rdExp);
    int w;
    rdExp = 16'h0;
    if (!en || int'(a) < int'(BASE) || int'(a) >= int'(BASE) + 2 * NWORDS) return 1'b0;
    w = (int'(a) - int'(BASE)) / 2;
    if (c == DATI || c == DATIP) rdExp = tbMem[w];
    else if (c == DATO) begin
      tbMem[w] = d;
      known[w] = 1'b1;
    end else if (a[0]) tbMem[w][15:8] = d[15:8];
    else tbMem[w][7:0] = d[7:0];
    mCount++;
    return 1'b1;
  endfunction

  task automatic armWrite(input logic [2:0] addr, input logic [31:0] data);
    @(negedge CLOCK);
    armwrite = 1'b1;
    armwaddr = addr;
    armwdata = data;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic armRead(input logic [2:0] addr, output logic [31:0] data);
    @(negedge CLOCK);
    armraddr = addr;
    #1 data = armrdata;
  endtask

  task automatic armWaitIdle(input string tag);
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && v[29]; i++) armRead(3'd1, v);
    checkOutput({tag, " armpend clear"}, {31'h0, v[29]}, 32'h0);
    @(negedge CLOCK);
  endtask

  task automatic armSetPtr(input int p);
    armWrite(3'd2, p);
    armWaitIdle("setptr");
    mPtr = (p + 1) % NWORDS;
  endtask

  task automatic armStore(input logic [15:0] v);
    armWrite(3'd3, {16'h0, v});
    armWaitIdle("store");
    tbMem[mPtr] = v;
    known[mPtr] = 1'b1;
    mPtr = (mPtr + 1) % NWORDS;
  endtask

  task automatic setEnable(input logic en);
    if (en !== mEn) armWrite(3'd1, {en, 31'h0});
    mEn = en;
  endtask

  task automatic busCycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                          input int armEdge, input logic [15:0] armVal,
                          output int lat, output logic [15:0] rd, output logic stray,
                          output logic relS, output logic [15:0] relD);
    lat = -1;
    rd = 16'h0;
    stray = 1'b0;
    @(negedge CLOCK);
    a_in_h = a;
    c_in_h = c;
    d_in_h = d;
    msyn_in_h = 1'b1;
    for (int e = 0; e < 40 && lat < 0; e++) begin
      @(negedge CLOCK);
      if (ssyn_out_h) begin
        lat = e;
        rd = d_out_h;
      end else if (d_out_h != 16'h0) stray = 1'b1;
      if (e == armEdge) begin
        armwrite = 1'b1;
        armwaddr = 3'd3;
        armwdata = {16'h0, armVal};
      end else armwrite = 1'b0;
    end
    armwrite = 1'b0;
    msyn_in_h = 1'b0;
    @(negedge CLOCK);
    relS = ssyn_out_h;
    relD = d_out_h;
  endtask

  task automatic applyStimulus(input string tag, input logic [17:0] a, input logic [1:0] c,
                               input logic [15:0] d, input logic expAck, input logic [15:0] expD);
    int lat;
    logic [15:0] rd, relD;
    logic stray, relS;
    busCycle(a, c, d, -1, 16'h0, lat, rd, stray, relS, relD);
    checkOutput({tag, " ack"}, {31'h0, lat >= 0}, {31'h0, expAck});
    if (expAck) begin
      checkOutput({tag, " latency"}, lat, ACK_LAT);
      checkOutput({tag, " data"}, {16'h0, rd}, {16'h0, expD});
    end
    checkOutput({tag, " idle bus"}, {31'h0, stray}, 32'h0);
    checkOutput({tag, " release"}, {15'h0, relS, relD}, 32'h0);
  endtask

  task automatic modelCycle(input string tag, input logic en, input logic [17:0] a,
                            input logic [1:0] c, input logic [15:0] d);
    logic ack;
    logic [15:0] exp;
    setEnable(en);
    ack = modelBus(en, a, c, d, exp);
    applyStimulus(tag, a, c, d, ack, exp);
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] rd, relD, dummy;
    logic stray, relS, seen, ack;
    int lat;

    vecs[0]  = '{1'b1, 18'o000040, DATO,  16'h1234, 1'b1, 16'h0000};
    vecs[1]  = '{1'b1, 18'o000040, DATI,  16'h0000, 1'b1, 16'h1234};
    vecs[2]  = '{1'b1, 18'o000041, DATOB, 16'hAB00, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 18'o000040, DATI,  16'h0000, 1'b1, 16'hAB34};
    vecs[4]  = '{1'b1, 18'o000040, DATOB, 16'h00CD, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 18'o000040, DATIP, 16'h0000, 1'b1, 16'hABCD};
    vecs[6]  = '{1'b1, 18'o020000, DATI,  16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 18'o020040, DATO,  16'hFFFF, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 18'o000040, DATI,  16'h0000, 1'b1, 16'hABCD};
    vecs[9]  = '{1'b0, 18'o000040, DATO,  16'h5555, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 18'o017776, DATO,  16'h5A5A, 1'b1, 16'h0000};
    vecs[11] = '{1'b1, 18'o017776, DATI,  16'h0000, 1'b1, 16'h5A5A};
    vecs[12] = '{1'b1, 18'o777776, DATI,  16'h0000, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 18'o000040, DATI,  16'h0000, 1'b1, 16'hABCD};

    for (int i = 0; i < NWORDS; i++) known[i] = 1'b0;

    repeat (3) @(negedge CLOCK);
    checkOutput("reset ssyn", {31'h0, ssyn_out_h}, 32'h0);
    checkOutput("reset dout", {16'h0, d_out_h}, 32'h0);
    RESET = 1'b1;
    armRead(3'd0, v); checkOutput("reg0 id", v, 32'h424D3005);
    armRead(3'd1, v); checkOutput("reg1 reset", v & 32'hA003FFFF, {14'h0, BASE});
    armRead(3'd2, v); checkOutput("reg2 reset", v, 32'h0);
    armRead(3'd4, v); checkOutput("reg4 reset", v, 32'h0);

    $display("[TB] ARM load and readback");
    armSetPtr(12'h00F);
    armStore(16'o123456);
    armRead(3'd2, v); checkOutput("armptr after store", v, 32'h11);
    armSetPtr(12'h010);
    armRead(3'd3, v); checkOutput("armdata readback", v, 32'o123456);
    armRead(3'd2, v); checkOutput("armptr after read", v, 32'h11);

    $display("[TB] first DATI");
    setEnable(1'b1);
    armRead(3'd1, v); checkOutput("reg1 enable", {31'h0, v[31]}, 32'h1);
    applyStimulus("first dati", 18'o000040, DATI, 16'h0, 1'b1, 16'o123456);
    ack = modelBus(1'b1, 18'o000040, DATI, 16'h0, dummy);
    armRead(3'd4, v); checkOutput("count after first", v, mCount);

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      setEnable(vecs[i].en);
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].c, vecs[i].d,
                    vecs[i].expAck, vecs[i].expD);
      ack = modelBus(vecs[i].en, vecs[i].a, vecs[i].c, vecs[i].d, dummy);
    end
    armRead(3'd4, v); checkOutput("count after table", v, mCount);

    $display("[TB] MSYN dropped during deskew");
    @(negedge CLOCK);
    a_in_h = 18'o000040; c_in_h = DATO; d_in_h = 16'hDEAD; msyn_in_h = 1'b1;
    repeat (6) @(negedge CLOCK);
    msyn_in_h = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK);
      if (ssyn_out_h) seen = 1'b1;
    end
    checkOutput("abort no ssyn", {31'h0, seen}, 32'h0);
    modelCycle("abort readback", 1'b1, 18'o000040, DATI, 16'h0);

    $display("[TB] INIT during REPLY");
    @(negedge CLOCK);
    a_in_h = 18'o000040; c_in_h = DATI; msyn_in_h = 1'b1;
    seen = 1'b0;
    for (int e = 0; e < 40 && !seen; e++) begin
      @(negedge CLOCK);
      seen = ssyn_out_h;
    end
    checkOutput("init ssyn before", {31'h0, seen}, 32'h1);
    init_in_h = 1'b1;
    @(negedge CLOCK);
    checkOutput("init ssyn drop", {31'h0, ssyn_out_h}, 32'h0);
    checkOutput("init dout drop", {16'h0, d_out_h}, 32'h0);
    init_in_h = 1'b0;
    msyn_in_h = 1'b0;
    repeat (2) @(negedge CLOCK);
    armRead(3'd4, v); checkOutput("init count kept", v, mCount);
    modelCycle("after init", 1'b1, 18'o000040, DATI, 16'h0);

    $display("[TB] ARM write colliding with bus ACCESS");
    armSetPtr(12'h02F);
    busCycle(18'o000140, DATO, 16'h1111, DESKEW + 1, 16'h2222, lat, rd, stray, relS, relD);
    checkOutput("collide ack latency", lat, ACK_LAT);
    ack = modelBus(1'b1, 18'o000140, DATO, 16'h1111, dummy);
    tbMem[12'h030] = 16'h2222;
    mPtr = 12'h031;
    armWaitIdle("collide");
    armRead(3'd2, v); checkOutput("collide armptr", v, mPtr);
    armRead(3'd3, v); checkOutput("collide armdata", v, 32'h2222);
    modelCycle("collide readback", 1'b1, 18'o000140, DATI, 16'h0);

    $display("[TB] random bus cycles");
    for (int i = 0; i < 30; i++) begin
      logic        en;
      logic [17:0] a;
      logic [1:0]  c;
      en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 4) == 0) a = 18'(8192 + $urandom_range(0, 262143 - 8192));
      else a = 18'($urandom_range(0, 8191));
      c = 2'($urandom_range(0, 3));
      if (c[1] == 1'b0 && !known[a[12:1]]) c = DATO;
      modelCycle($sformatf("rand%0d", i), en, a, c, 16'($urandom));
    end
    armRead(3'd4, v); checkOutput("count after random", v, mCount);
    armWrite(3'd4, 32'h0);
    armRead(3'd4, v); checkOutput("count clear", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
